// File: rtl/branch_ex.sv
// Branch execute stage: resolves branches/jumps, pulses a fetch redirect, squashes
// the wrong-path window and registers the jump link write. Counters under BRANCH_STATS_EN.
module branch_ex #(
  parameter int FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        is_nop_in,
  input  logic        is_jmp_in,
  input  logic        is_imm_type_in,
  input  logic        zero_ext_in,
  input  logic [1:0]  op_in,
  input  logic [4:0]  rd_in,
  input  logic [19:0] imm_in,
  input  logic [31:0] pc_in,
  input  logic [31:0] rs1_val,
  input  logic [31:0] rs2_val,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        flush,
  output logic        wb_en,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic [31:0] stat_taken,
  output logic [31:0] stat_resolved
);

  typedef enum logic {RUN, SQUASH} state_t;

  state_t      state, state_next;
  logic [2:0]  count, count_next;
  logic [31:0] ext, target;
  logic        cond, taken, valid;

  always_comb begin
    ext = zero_ext_in ? {12'b0, imm_in} : {{12{imm_in[19]}}, imm_in};
    if (is_imm_type_in) target = (rs1_val + ext) & 32'hFFFF_FFFC;
    else                target = pc_in + (ext << 2);
  end

  always_comb begin
    cond = 1'b0;
    case (op_in)
      2'b00: cond = (rs1_val == rs2_val);
      2'b01: cond = (rs1_val != rs2_val);
      2'b10: cond = zero_ext_in ? (rs1_val < rs2_val) : ($signed(rs1_val) < $signed(rs2_val));
      2'b11: cond = zero_ext_in ? (rs1_val >= rs2_val) : ($signed(rs1_val) >= $signed(rs2_val));
      default: cond = 1'b0;
    endcase
  end

  assign taken = is_jmp_in | cond;
  assign valid = !is_nop_in && !stall && (state == RUN);
  assign flush = (state == SQUASH);

  always_comb begin
    state_next = state;
    count_next = count;
    case (state)
      RUN: begin
        if (valid && taken) begin
          state_next = SQUASH;
          count_next = 3'(FLUSH_CYCLES);
        end
      end
      SQUASH: begin
        // only non-stalled edges consume the squash window
        if (!stall) begin
          if (count == 3'd1) begin
            state_next = RUN;
            count_next = 3'd0;
          end else begin
            count_next = count - 3'd1;
          end
        end
      end
      default: begin
        state_next = RUN;
        count_next = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
      count <= 3'd0;
    end else begin
      state <= state_next;
      count <= count_next;
    end
  end

  // redirect pulse is recomputed every edge, so it drops even while stalled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      redirect_valid <= 1'b0;
      redirect_pc    <= 32'd0;
    end else begin
      redirect_valid <= valid && taken;
      if (valid && taken) redirect_pc <= target;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_en   <= 1'b0;
      wb_rd   <= 5'd0;
      wb_data <= 32'd0;
    end else if (!stall) begin
      if (valid && is_jmp_in && (rd_in != 5'd0)) begin
        wb_en   <= 1'b1;
        wb_rd   <= rd_in;
        wb_data <= pc_in + 32'd4;
      end else begin
        wb_en <= 1'b0;
      end
    end
  end

`ifdef BRANCH_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_taken    <= 32'd0;
      stat_resolved <= 32'd0;
    end else if (valid) begin
      if (stat_resolved != 32'hFFFF_FFFF) stat_resolved <= stat_resolved + 32'd1;
      if (taken && stat_taken != 32'hFFFF_FFFF) stat_taken <= stat_taken + 32'd1;
    end
  end
`else
  assign stat_taken    = 32'd0;
  assign stat_resolved = 32'd0;
`endif

endmodule

// File: tb/tb_branch_ex.sv
// Randomised + directed bench for branch_ex: a high-level model pushes the expected
// post-edge outputs into a queue; a monitor pops and compares once per clock.
module tb_branch_ex;
  localparam int FLUSH = 2;

  logic        clk = 1'b0;
  logic        rst, stall, is_nop_in, is_jmp_in, is_imm_type_in, zero_ext_in;
  logic [1:0]  op_in;
  logic [4:0]  rd_in;
  logic [19:0] imm_in;
  logic [31:0] pc_in, rs1_val, rs2_val;
  logic        redirect_valid, flush, wb_en;
  logic [31:0] redirect_pc, wb_data, stat_taken, stat_resolved;
  logic [4:0]  wb_rd;

  branch_ex #(.FLUSH_CYCLES(FLUSH)) dut (
    .clk(clk), .rst(rst), .stall(stall), .is_nop_in(is_nop_in), .is_jmp_in(is_jmp_in),
    .is_imm_type_in(is_imm_type_in), .zero_ext_in(zero_ext_in), .op_in(op_in),
    .rd_in(rd_in), .imm_in(imm_in), .pc_in(pc_in), .rs1_val(rs1_val), .rs2_val(rs2_val),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .flush(flush),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .stat_taken(stat_taken), .stat_resolved(stat_resolved)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic rst, stall, nop, jmp, immt, zx;
    logic [1:0] op; logic [4:0] rd; logic [19:0] imm;
    logic [31:0] pc, rs1, rs2;
  } in_t;

  typedef struct {
    logic rv; logic [31:0] rpc; logic fl; logic we; logic [4:0] wrd;
    logic [31:0] wd, st, sr;
  } out_t;

  out_t cur;
  out_t q[$];
  int   squash_left = 0;
  int   n_cmp = 0, n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic in_t mk();
    in_t x;
    x.rst = 0; x.stall = 0; x.nop = 1; x.jmp = 0; x.immt = 0; x.zx = 0;
    x.op = 0; x.rd = 0; x.imm = 0; x.pc = 0; x.rs1 = 0; x.rs2 = 0;
    return x;
  endfunction

  function automatic longint ext_of(input in_t x);
    if (x.zx) return longint'(x.imm);
    return (x.imm >= 20'h80000) ? longint'(x.imm) - 64'sd1048576 : longint'(x.imm);
  endfunction

  function automatic logic [31:0] target_of(input in_t x);
    longint t;
    if (x.immt) t = (longint'(x.rs1) + ext_of(x)) & 64'h0000_0000_FFFF_FFFC;
    else        t = (longint'(x.pc) + ext_of(x) * 4) & 64'h0000_0000_FFFF_FFFF;
    return t[31:0];
  endfunction

  function automatic bit taken_of(input in_t x);
    if (x.jmp) return 1;
    case (x.op)
      2'd0: return x.rs1 == x.rs2;
      2'd1: return x.rs1 != x.rs2;
      2'd2: return x.zx ? (longint'(x.rs1) < longint'(x.rs2)) : (int'(x.rs1) < int'(x.rs2));
      default: return x.zx ? (longint'(x.rs1) >= longint'(x.rs2)) : (int'(x.rs1) >= int'(x.rs2));
    endcase
  endfunction

  task automatic model(input in_t x);
    bit v, t;
    if (x.rst) begin
      cur = '{default: 0};
      squash_left = 0;
      return;
    end
    v = !x.nop && !x.stall && squash_left == 0;
    t = taken_of(x);
    cur.rv = v && t;
    if (v && t) begin
      cur.rpc = target_of(x);
      squash_left = FLUSH;
    end else if (!x.stall && squash_left > 0) begin
      squash_left--;
    end
    cur.fl = squash_left > 0;
    if (!x.stall) begin
      if (v && x.jmp && x.rd != 0) begin
        cur.we = 1; cur.wrd = x.rd; cur.wd = x.pc + 32'd4;
      end else cur.we = 0;
    end
`ifdef BRANCH_STATS_EN
    if (v) begin
      if (cur.sr != 32'hFFFF_FFFF) cur.sr++;
      if (t && cur.st != 32'hFFFF_FFFF) cur.st++;
    end
`endif
  endtask

  // Entered and left at posedge+2; the monitor samples at posedge+1.
  task automatic cycle(input in_t x);
    rst = x.rst; stall = x.stall; is_nop_in = x.nop; is_jmp_in = x.jmp;
    is_imm_type_in = x.immt; zero_ext_in = x.zx; op_in = x.op; rd_in = x.rd;
    imm_in = x.imm; pc_in = x.pc; rs1_val = x.rs1; rs2_val = x.rs2;
    model(x);
    q.push_back(cur);
    if (x.rst) begin
      #1;
      chk("async_rst_flush", {31'b0, flush}, 32'd0);
      chk("async_rst_redirect", {31'b0, redirect_valid}, 32'd0);
      chk("async_rst_wb_en", {31'b0, wb_en}, 32'd0);
      chk("async_rst_redirect_pc", redirect_pc, 32'd0);
    end
    @(posedge clk); #2;
  endtask

  task automatic idle(input int n, input logic st);
    in_t x;
    x = mk(); x.stall = st;
    for (int i = 0; i < n; i++) cycle(x);
  endtask

  initial begin : monitor
    out_t e;
    forever begin
      @(posedge clk); #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("redirect_valid", {31'b0, redirect_valid}, {31'b0, e.rv});
        chk("redirect_pc", redirect_pc, e.rpc);
        chk("flush", {31'b0, flush}, {31'b0, e.fl});
        chk("wb_en", {31'b0, wb_en}, {31'b0, e.we});
        chk("wb_rd", {27'b0, wb_rd}, {27'b0, e.wrd});
        chk("wb_data", wb_data, e.wd);
        chk("stat_taken", stat_taken, e.st);
        chk("stat_resolved", stat_resolved, e.sr);
        $display("t=%0t rv=%0d rpc=%08h flush=%0d wb=%0d rd=%0d wd=%08h st=%0d sr=%0d",
                 $time, redirect_valid, redirect_pc, flush, wb_en, wb_rd, wb_data,
                 stat_taken, stat_resolved);
      end
    end
  end

  initial begin : stim
    in_t x;
    cur = '{default: 0};
    rst = 1; stall = 0; is_nop_in = 1; is_jmp_in = 0; is_imm_type_in = 0; zero_ext_in = 0;
    op_in = 0; rd_in = 0; imm_in = 0; pc_in = 0; rs1_val = 0; rs2_val = 0;
    repeat (2) @(posedge clk);
    #2;
    chk("reset_redirect_valid", {31'b0, redirect_valid}, 32'd0);
    chk("reset_flush", {31'b0, flush}, 32'd0);
    chk("reset_wb_en", {31'b0, wb_en}, 32'd0);
    chk("reset_wb_data", wb_data, 32'd0);
    chk("reset_stat_taken", stat_taken, 32'd0);

    // BEQ taken, PC-relative; the next two instructions are squashed
    x = mk(); x.nop = 0; x.op = 2'd0; x.rs1 = 32'h5; x.rs2 = 32'h5; x.pc = 32'h100; x.imm = 20'h4;
    cycle(x);
    x.pc = 32'h104; cycle(x);
    x.pc = 32'h108; x.jmp = 1; x.rd = 5'd3; cycle(x);
    idle(1, 0);
    // BLT signed taken, then unsigned not taken
    x = mk(); x.nop = 0; x.op = 2'd2; x.rs1 = 32'hFFFF_FFFF; x.rs2 = 32'h1; x.pc = 32'h300; x.imm = 20'h10;
    cycle(x); idle(2, 0);
    x.zx = 1; cycle(x); idle(1, 0);
    // indirect jump with link, then rd=0
    x = mk(); x.nop = 0; x.jmp = 1; x.immt = 1; x.rs1 = 32'h1003; x.imm = 20'hFFFFF; x.rd = 5'd5; x.pc = 32'h200;
    cycle(x); idle(2, 0);
    x.rd = 5'd0; cycle(x); idle(2, 0);
    // taken branch then 3 stalled cycles inside the squash window
    x = mk(); x.nop = 0; x.op = 2'd1; x.rs1 = 32'h1; x.rs2 = 32'h2; x.pc = 32'h400; x.imm = 20'hFFFFE;
    cycle(x); idle(3, 1); idle(3, 0);
    // PC-relative wrap, then reset in the middle of the squash window
    x = mk(); x.nop = 0; x.jmp = 1; x.pc = 32'hFFFF_FFF0; x.imm = 20'h8; x.rd = 5'd1;
    cycle(x); idle(1, 0);
    x = mk(); x.rst = 1; cycle(x);
    idle(1, 0);
    // 3 taken + 2 not-taken + 1 squashed
    x = mk(); x.nop = 0; x.op = 2'd0; x.rs1 = 32'h7; x.rs2 = 32'h7; x.pc = 32'h500;
    cycle(x);
    x.jmp = 1; cycle(x); x.jmp = 0;
    idle(1, 0);
    x.rs2 = 32'h8; cycle(x); cycle(x);
    x.rs2 = 32'h7; cycle(x); idle(2, 0);
    x.op = 2'd3; x.rs2 = 32'h1; cycle(x); idle(2, 0);
`ifdef BRANCH_STATS_EN
    chk("stats_taken_total", stat_taken, 32'd3);
    chk("stats_resolved_total", stat_resolved, 32'd5);
`else
    chk("stats_taken_off", stat_taken, 32'd0);
    chk("stats_resolved_off", stat_resolved, 32'd0);
`endif

    for (int i = 0; i < 400; i++) begin
      x = mk();
      x.rst   = ($urandom_range(0, 99) == 0);
      x.stall = ($urandom_range(0, 3) == 0);
      x.nop   = ($urandom_range(0, 4) == 0);
      x.jmp   = ($urandom_range(0, 3) == 0);
      x.immt  = 1'($urandom_range(0, 1));
      x.zx    = 1'($urandom_range(0, 1));
      x.op    = 2'($urandom_range(0, 3));
      x.rd    = 5'($urandom);
      x.imm   = 20'($urandom);
      x.pc    = $urandom;
      x.rs1   = $urandom;
      x.rs2   = ($urandom_range(0, 2) == 0) ? x.rs1 : $urandom;
      cycle(x);
    end
    idle(2, 0);

    for (int i = 0; i < 5 && q.size() != 0; i++) @(posedge clk);
    #2;
    chk("scoreboard_drained", q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
